// File: rtl/rtio_timebase.sv
// Free-running timestamp counter with run/pause control, offset load and per-channel compare.
// Optional RTIO_TIMEBASE_LATCH_EN adds a snapshot latch (i_latch_req / o_latch_value / o_latch_valid).
module rtio_timebase #(
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_CMP       = 4,
  parameter int INC_STEP      = 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic                             i_stop,
  input  logic                             i_clear,
  input  logic [COUNTER_WIDTH-1:0]         i_counter_offset,
  input  logic                             i_offset_en,
  input  logic [NUM_CMP*COUNTER_WIDTH-1:0] i_cmp_value,
  input  logic [NUM_CMP-1:0]               i_cmp_arm,
  output logic [COUNTER_WIDTH-1:0]         o_counter,
  output logic                             o_running,
  output logic                             o_overflow,
  output logic [NUM_CMP-1:0]               o_cmp_match,
  output logic [NUM_CMP-1:0]               o_cmp_pending
`ifdef RTIO_TIMEBASE_LATCH_EN
  ,
  input  logic                             i_latch_req,
  output logic [COUNTER_WIDTH-1:0]         o_latch_value,
  output logic                             o_latch_valid
`endif
);

  // state   | meaning
  // IDLE    | cleared or never started; counter holds
  // RUN     | counter advances by INC_STEP each cycle
  // PAUSED  | stopped after running; counter holds
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;

  // Extra headroom so a step larger than the counter range still yields a carry.
  localparam int SW = COUNTER_WIDTH + 17;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_running;
  logic                     w_inc;
  logic [COUNTER_WIDTH-1:0] r_counter;
  logic                     r_overflow;
  logic [SW-1:0]            w_sum;
  logic                     w_carry;
  logic [COUNTER_WIDTH-1:0] r_cmp_val [NUM_CMP];
  logic [NUM_CMP-1:0]       r_cmp_match;
  logic [NUM_CMP-1:0]       r_cmp_pending;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else if (i_offset_en) begin
      w_state_nxt = r_state;
    end else if (i_stop) begin
      if (r_state == ST_RUN) w_state_nxt = ST_PAUSED;
    end else if (i_start) begin
      if (r_state != ST_RUN) w_state_nxt = ST_RUN;
    end
  end

  always_comb begin
    w_inc   = (r_state == ST_RUN) && !i_clear && !i_offset_en && !i_stop;
    w_sum   = SW'(r_counter) + SW'(INC_STEP);
    w_carry = |w_sum[SW-1:COUNTER_WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_counter  <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_counter  <= '0;
      r_overflow <= 1'b0;
    end else if (i_offset_en) begin
      r_counter <= i_counter_offset;
    end else if (w_inc) begin
      r_counter <= w_sum[COUNTER_WIDTH-1:0];
      if (w_carry) r_overflow <= 1'b1;
    end
  end

  // Arming takes precedence over matching in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CMP; i++) r_cmp_val[i] <= '0;
      r_cmp_match   <= '0;
      r_cmp_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        if (i_cmp_arm[i]) begin
          r_cmp_val[i]     <= i_cmp_value[i*COUNTER_WIDTH +: COUNTER_WIDTH];
          r_cmp_pending[i] <= 1'b1;
          r_cmp_match[i]   <= 1'b0;
        end else if (r_cmp_pending[i] && (r_cmp_val[i] == r_counter)) begin
          r_cmp_pending[i] <= 1'b0;
          r_cmp_match[i]   <= 1'b1;
        end else begin
          r_cmp_match[i] <= 1'b0;
        end
      end
    end
  end

`ifdef RTIO_TIMEBASE_LATCH_EN
  logic [COUNTER_WIDTH-1:0] r_latch_value;
  logic                     r_latch_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latch_value <= '0;
      r_latch_valid <= 1'b0;
    end else begin
      r_latch_valid <= i_latch_req;
      if (i_latch_req) r_latch_value <= r_counter;
    end
  end

  assign o_latch_value = r_latch_value;
  assign o_latch_valid = r_latch_valid;
`endif

  assign o_counter     = r_counter;
  assign o_running     = r_running;
  assign o_overflow    = r_overflow;
  assign o_cmp_match   = r_cmp_match;
  assign o_cmp_pending = r_cmp_pending;

endmodule
